// File: rtl/panel_pkg.sv
// Shared constants for the panel push-button front end.
package panel_pkg;

  localparam int unsigned N_KEYS_DEF = 13;

  localparam int unsigned KEY_UP   = 0;
  localparam int unsigned KEY_DN   = 1;
  localparam int unsigned KEY_LFT  = 2;
  localparam int unsigned KEY_RHT  = 3;
  localparam int unsigned KEY_ENT  = 4;
  localparam int unsigned KEY_ESC  = 5;
  localparam int unsigned KEY_ST0  = 6;
  localparam int unsigned KEY_ST1  = 7;
  localparam int unsigned KEY_ST2  = 8;
  localparam int unsigned KEY_ST3  = 9;
  localparam int unsigned KEY_ST4  = 10;
  localparam int unsigned KEY_ST5  = 11;
  localparam int unsigned KEY_RINK = 12;

  localparam int unsigned TICK_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [TICK_W-1:0] tick_cnt_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchroniser, tick-paced debounce counter, level, pulses and
// sticky press latch.
module key_debounce_cell
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_raw_n,
  input  logic latch_clr,
  output logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_latch,
  output logic key_n_next,
  output logic event_next
);

  localparam cnt_t CntMax = cnt_t'(DEBOUNCE_TICKS - 1);

  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic level_q, level_d;
  logic press_q, press_d, release_q, release_d;
  logic latch_q, latch_d;
  cnt_t cnt_q, cnt_d;

  always_comb begin
    sync1_d   = key_raw_n;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any agreeing cycle restarts the count, so a glitch between ticks is forgotten.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntMax) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
    // Set comes from the visible pulse so a coincident host clear loses.
    latch_d = press_q | (latch_q & ~latch_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      latch_q   <= latch_d;
    end
  end

  assign key_n         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_latch   = latch_q;
  assign key_n_next    = reset ? 1'b1 : level_d;
  assign event_next    = ~reset & (press_d | release_d);

endmodule

// File: rtl/key_debounce.sv
// Panel key conditioning: shared debounce prescaler, per-key cells and
// registered all-released / any-event summaries.
module key_debounce
  import panel_pkg::*;
#(
  parameter int unsigned N_KEYS         = N_KEYS_DEF,
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw_n,
  input  logic [N_KEYS-1:0] latch_clr,
  output logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] press_latch,
  output logic              all_released,
  output logic              any_event
);

  localparam tick_cnt_t TickLast = tick_cnt_t'(TICK_DIV - 1);

  tick_cnt_t         pre_q, pre_d;
  logic              tick;
  logic [N_KEYS-1:0] key_n_next, event_next;
  logic              all_rel_q, all_rel_d, any_q, any_d;

  always_comb begin
    tick      = (pre_q == TickLast);
    pre_d     = tick ? '0 : pre_q + tick_cnt_t'(1);
    all_rel_d = &key_n_next;
    any_d     = |event_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      all_rel_q <= 1'b1;
      any_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      all_rel_q <= all_rel_d;
      any_q     <= any_d;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .key_raw_n    (key_raw_n[i]),
      .latch_clr    (latch_clr[i]),
      .key_n        (key_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_latch  (press_latch[i]),
      .key_n_next   (key_n_next[i]),
      .event_next   (event_next[i])
    );
  end

  assign all_released = all_rel_q;
  assign any_event    = any_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key activity
// compared every cycle against a behavioural model.
module tb_key_debounce;

  localparam int N  = 13;
  localparam int TD = 4;
  localparam int DT = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   key_raw_n, latch_clr;
  logic [N-1:0]   key_n, press_pulse, release_pulse, press_latch;
  logic           all_released, any_event;

  int n_checks = 0;
  int n_errors = 0;

  // Model: synced level = raw from two clocks ago; a key is accepted once the synced
  // level has disagreed with the accepted level across DT ticks without interruption.
  bit m_s1[N], m_s2[N], m_lvl[N], m_press[N], m_rel[N], m_latch[N];
  int m_held[N];
  int m_cyc;
  bit m_allrel, m_any;

  key_debounce #(
    .N_KEYS        (N),
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .key_raw_n    (key_raw_n),
    .latch_clr    (latch_clr),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_latch  (press_latch),
    .all_released (all_released),
    .any_event    (any_event)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    bit tick, p, r, nl;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 1; m_s2[i] = 1; m_lvl[i] = 1; m_press[i] = 0;
        m_rel[i] = 0; m_latch[i] = 0; m_held[i] = 0;
      end
      m_cyc = 0; m_allrel = 1; m_any = 0;
    end else begin
      tick  = (m_cyc % TD) == TD - 1;
      m_cyc = tick ? 0 : m_cyc + 1;
      m_allrel = 1; m_any = 0;
      for (int i = 0; i < N; i++) begin
        nl = m_press[i] | (m_latch[i] & !latch_clr[i]);
        p = 0; r = 0;
        if (m_s2[i] == m_lvl[i]) m_held[i] = 0;
        else if (tick) begin
          m_held[i]++;
          if (m_held[i] == DT) begin
            m_lvl[i] = m_s2[i]; m_held[i] = 0;
            p = !m_lvl[i]; r = m_lvl[i];
          end
        end
        m_s2[i] = m_s1[i]; m_s1[i] = key_raw_n[i];
        m_press[i] = p; m_rel[i] = r; m_latch[i] = nl;
        m_allrel &= m_lvl[i]; m_any |= p | r;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("key_n", 32'(key_n), 32'(pack(m_lvl)));
    check_eq("press_pulse", 32'(press_pulse), 32'(pack(m_press)));
    check_eq("release_pulse", 32'(release_pulse), 32'(pack(m_rel)));
    check_eq("press_latch", 32'(press_latch), 32'(pack(m_latch)));
    check_eq("all_released", 32'(all_released), 32'(m_allrel));
    check_eq("any_event", 32'(any_event), 32'(m_any));
  endtask

  // Edges until the chosen pulse of key idx appears; 99 if it never does.
  task automatic wait_pulse(input int idx, input bit rel, output int n);
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((rel ? release_pulse[idx] : press_pulse[idx]) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic settle(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  initial begin
    int n, ev, lows;
    reset = 1'b1; key_raw_n = '0; latch_clr = '0;
    settle(3);
    check_eq("rst_key_n", 32'(key_n), 32'h1FFF);
    check_eq("rst_all_released", 32'(all_released), 32'd1);
    check_eq("rst_pulses", 32'(press_pulse | release_pulse), 32'd0);

    // All keys held through reset are accepted together after release.
    reset = 1'b0;
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (press_pulse === 13'h1FFF) begin n = k; break; end
    end
    check_eq("rst_press_all_lat", 32'(n >= 11 && n <= 15), 32'd1);
    step();
    check_eq("rst_latch_all", 32'(press_latch), 32'h1FFF);

    key_raw_n = '1;
    settle(20);
    latch_clr = '1;
    step();
    latch_clr = '0;
    step();
    check_eq("latch_cleared", 32'(press_latch), 32'd0);

    // Clean press on ENT at a random prescaler phase.
    settle($urandom_range(0, 3));
    key_raw_n[4] = 1'b0;
    wait_pulse(4, 1'b0, n);
    check_eq("ent_press_lat", 32'(n >= 11 && n <= 15), 32'd1);
    check_eq("ent_key_n", 32'(key_n[4]), 32'd0);
    check_eq("ent_any_event", 32'(any_event), 32'd1);
    check_eq("ent_all_released", 32'(all_released), 32'd0);
    step();
    check_eq("ent_pulse_1cyc", 32'(press_pulse[4]), 32'd0);
    key_raw_n[4] = 1'b1;
    settle(20);

    // Bounce on UP shorter than a tick interval.
    ev = 0; lows = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) key_raw_n[0] = ~key_raw_n[0];
      step();
      ev += int'(press_pulse[0] | release_pulse[0]);
      lows += int'(!key_n[0]);
    end
    key_raw_n[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      ev += int'(press_pulse[0] | release_pulse[0]);
      lows += int'(!key_n[0]);
    end
    check_eq("bounce_events", 32'(ev), 32'd0);
    check_eq("bounce_key_low", 32'(lows), 32'd0);

    // Press, release and host clear of UP's latch.
    key_raw_n[0] = 1'b0;
    wait_pulse(0, 1'b0, n);
    check_eq("up_press_lat", 32'(n >= 11 && n <= 15), 32'd1);
    step();
    key_raw_n[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    check_eq("up_release_lat", 32'(n >= 11 && n <= 15), 32'd1);
    check_eq("up_latch_kept", 32'(press_latch[0]), 32'd1);
    latch_clr[0] = 1'b1;
    step();
    latch_clr[0] = 1'b0;
    check_eq("up_latch_clr", 32'(press_latch[0]), 32'd0);

    // Host clear collides with ESC's press pulse.
    key_raw_n[5] = 1'b0;
    wait_pulse(5, 1'b0, n);
    check_eq("esc_press_lat", 32'(n >= 11 && n <= 15), 32'd1);
    latch_clr[5] = 1'b1;
    step();
    latch_clr[5] = 1'b0;
    check_eq("esc_collision_latch", 32'(press_latch[5]), 32'd1);
    step();
    check_eq("esc_latch_hold", 32'(press_latch[5]), 32'd1);
    key_raw_n[5] = 1'b1;
    settle(20);

    // Reset part-way through LFT's debounce.
    key_raw_n[2] = 1'b0;
    settle(8);
    reset = 1'b1;
    step();
    check_eq("mid_rst_key_n", 32'(key_n[2]), 32'd1);
    check_eq("mid_rst_latch", 32'(press_latch), 32'd0);
    reset = 1'b0;
    wait_pulse(2, 1'b0, n);
    check_eq("mid_rst_press_lat", 32'(n >= 11 && n <= 15), 32'd1);
    key_raw_n[2] = 1'b1;
    settle(20);

    // Random key activity, host clears and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int idx = int'($urandom_range(0, N - 1));
        key_raw_n[idx] = ~key_raw_n[idx];
      end
      latch_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; latch_clr = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
